pia_multiport: RTL and testbench

- Parametrised successor to the team's 6820-style PIA.
- Provides NUM_PORTS peripheral ports, each PORT_W bits wide, on one shared register bus.
- Each port has:
  - a data direction register (DDR) and an output register (OR);
  - a control register (CR);
  - two interrupt inputs, C1 and C2, with edge-select flags;
  - a C2 output line with handshake, pulse and manual modes.
- Sits between the CPU bus decode and the peripheral pins. Drives per-port active-low IRQs.

---
 rtl/pia_pkg.sv | 29 ++
 rtl/pia_multiport_if.sv | 15 +
 rtl/pia_port.sv | 162 ++++++++++++++++
 rtl/pia_multiport.sv | 81 ++++++++
 tb/tb_pia_multiport.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pia_pkg.sv
// Shared constants and types for the multiport PIA: control-register bit
// positions, C2 output modes, C2 sequencer states and the pulse counter width.
package pia_pkg;

   localparam int CR_IRQ1   = 7;
   localparam int CR_IRQ2   = 6;
   localparam int CR_C2DIR  = 5;
   localparam int CR_C2M1   = 4;
   localparam int CR_C2M0   = 3;
   localparam int CR_ORSEL  = 2;
   localparam int CR_C1EDGE = 1;
   localparam int CR_C1EN   = 0;

   localparam int PCNT_W = 4;

   typedef enum logic [1:0] {
      C2_HANDSHAKE = 2'b00,
      C2_PULSE     = 2'b01,
      C2_LOW       = 2'b10,
      C2_HIGH      = 2'b11
   } c2_mode_e;

   typedef enum logic [1:0] {
      C2S_IDLE   = 2'b00,
      C2S_HSWAIT = 2'b01,
      C2S_PULSE  = 2'b10
   } c2_state_e;

endpackage

// File: rtl/pia_multiport_if.sv
// CPU-side register bus of the multiport PIA. The CPU decode is the master,
// the PIA is the slave; DO is the registered read data returned by the PIA.
interface pia_multiport_if #(
   parameter int PORT_W = 8,
   parameter int RS_W   = 2
);
   logic              cs;
   logic              rw;
   logic [RS_W-1:0]   RS;
   logic [PORT_W-1:0] DI;
   logic [PORT_W-1:0] DO;

   modport master (output cs, output rw, output RS, output DI, input DO);
   modport slave  (input cs, input rw, input RS, input DI, output DO);
endinterface

// File: rtl/pia_port.sv
// One PIA peripheral port: CR/DDR/OR registers, C1/C2 synchronisers and
// edge flags, the C2 output sequencer (handshake / pulse / static) and irq.
module pia_port
   import pia_pkg::*;
#(
   parameter int PORT_W       = 8,
   parameter int PULSE_CYCLES = 1,
   parameter bit WSTROBE      = 1'b0
) (
   input  logic              clk_i,
   input  logic              nreset_i,
   input  logic              acc_i,
   input  logic              rw_i,
   input  logic              rs0_i,
   input  logic [PORT_W-1:0] di_i,
   input  logic [PORT_W-1:0] pi_i,
   input  logic              c1_i,
   input  logic              c2i_i,
   output logic [PORT_W-1:0] po_o,
   output logic [PORT_W-1:0] pdir_o,
   output logic [PORT_W-1:0] rdata_o,
   output logic              c2o_o,
   output logic              irq_o
);

   localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES);

   logic [5:0]        cr_q, cr_d;
   logic              flag1_q, flag1_d, flag2_q, flag2_d;
   logic [PORT_W-1:0] or_q, or_d, ddr_q, ddr_d;
   logic [2:0]        c1_sync_q, c2_sync_q;
   logic              irq_q, irq_d;
   c2_state_e         state_q, state_d;
   logic [PCNT_W-1:0] cnt_q, cnt_d;
   logic              c2o_q, c2o_d;
   c2_mode_e          mode;

   logic or_sel, data_acc, cr_wr, trigger, clr, set1, set2;

   // Sync stages: [0] first flop, [1] second flop, [2] previous value for edge compare
   assign or_sel   = cr_q[CR_ORSEL];
   assign data_acc = acc_i & ~rs0_i & or_sel;
   assign cr_wr    = acc_i & ~rw_i & rs0_i;
   assign trigger  = data_acc & (WSTROBE ? ~rw_i : rw_i);
   assign clr      = data_acc & rw_i;
   assign set1     = cr_q[CR_C1EDGE] ? (c1_sync_q[1] & ~c1_sync_q[2])
                                     : (~c1_sync_q[1] & c1_sync_q[2]);
   assign set2     = ~cr_q[CR_C2DIR] &
                     (cr_q[CR_C2M1] ? (c2_sync_q[1] & ~c2_sync_q[2])
                                    : (~c2_sync_q[1] & c2_sync_q[2]));

   // Register writes, flag set/clear (set wins) and irq from the new flag values
   always_comb begin
      cr_d  = cr_q;
      or_d  = or_q;
      ddr_d = ddr_q;
      if (acc_i && !rw_i) begin
         if (rs0_i)       cr_d  = di_i[5:0];
         else if (or_sel) or_d  = di_i;
         else             ddr_d = di_i;
      end
      flag1_d = set1 | (flag1_q & ~clr);
      flag2_d = set2 | (flag2_q & ~clr);
      irq_d   = ~((flag1_d & cr_d[CR_C1EN]) |
                  (flag2_d & cr_d[CR_C2M0] & ~cr_d[CR_C2DIR]));
   end

   // C2 output sequencer next state; a CR write restarts it in the new mode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c2o_d   = 1'b1;
      mode    = c2_mode_e'(cr_q[CR_C2M1:CR_C2M0]);
      if (cr_wr) begin
         state_d = C2S_IDLE;
         cnt_d   = '0;
         c2o_d   = ~(cr_d[CR_C2DIR] & (c2_mode_e'(cr_d[CR_C2M1:CR_C2M0]) == C2_LOW));
      end else if (cr_q[CR_C2DIR]) begin
         case (mode)
            C2_HANDSHAKE: begin
               if (trigger) begin
                  state_d = C2S_HSWAIT;
                  c2o_d   = 1'b0;
               end else if (state_q == C2S_HSWAIT) begin
                  if (set1) state_d = C2S_IDLE;
                  else      c2o_d   = 1'b0;
               end
            end
            C2_PULSE: begin
               if (trigger) begin
                  state_d = C2S_PULSE;
                  cnt_d   = PULSE_LOAD;
                  c2o_d   = 1'b0;
               end else if (state_q == C2S_PULSE) begin
                  if (cnt_q > PCNT_W'(1)) begin
                     cnt_d = cnt_q - PCNT_W'(1);
                     c2o_d = 1'b0;
                  end else begin
                     cnt_d   = '0;
                     state_d = C2S_IDLE;
                  end
               end
            end
            C2_LOW:  c2o_d = 1'b0;
            default: c2o_d = 1'b1;
         endcase
      end else begin
         state_d = C2S_IDLE;
         cnt_d   = '0;
      end
   end

   // Read data for this port: CR with flags, pin/OR mix, or DDR
   always_comb begin
      rdata_o = '0;
      if (rs0_i)       rdata_o[7:0] = {flag1_q, flag2_q, cr_q};
      else if (or_sel) rdata_o = (or_q & ddr_q) | (pi_i & ~ddr_q);
      else             rdata_o = ddr_q;
   end

   // Registers, flags and synchronisers; reset preloads the syncs with the pins
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         cr_q      <= '0;
         or_q      <= '0;
         ddr_q     <= '0;
         flag1_q   <= 1'b0;
         flag2_q   <= 1'b0;
         irq_q     <= 1'b1;
         c1_sync_q <= {3{c1_i}};
         c2_sync_q <= {3{c2i_i}};
      end else begin
         cr_q      <= cr_d;
         or_q      <= or_d;
         ddr_q     <= ddr_d;
         flag1_q   <= flag1_d;
         flag2_q   <= flag2_d;
         irq_q     <= irq_d;
         c1_sync_q <= {c1_sync_q[1], c1_sync_q[0], c1_i};
         c2_sync_q <= {c2_sync_q[1], c2_sync_q[0], c2i_i};
      end
   end

   // C2 sequencer state register; reset abandons any pulse or handshake
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_q <= C2S_IDLE;
         cnt_q   <= '0;
         c2o_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c2o_q   <= c2o_d;
      end
   end

   assign po_o   = or_q;
   assign pdir_o = ddr_q;
   assign c2o_o  = c2o_q;
   assign irq_o  = irq_q;

endmodule

// File: rtl/pia_multiport.sv
// Multiport PIA top: register-select decode, per-port instances and the
// registered DO read mux. Define PIA_IRQ_COMBINED_EN to add irq_any.
module pia_multiport
   import pia_pkg::*;
#(
   parameter int         NUM_PORTS    = 2,
   parameter int         PORT_W       = 8,
   parameter int         PULSE_CYCLES = 1,
   parameter logic [7:0] WSTROBE_MASK = 8'b0000_0010,
   parameter int         RS_W         = $clog2(NUM_PORTS) + 1
) (
   input  logic                        enable,
   input  logic                        nreset,
   pia_multiport_if.slave              bus,
   input  logic [NUM_PORTS*PORT_W-1:0] PI,
   output logic [NUM_PORTS*PORT_W-1:0] PO,
   output logic [NUM_PORTS*PORT_W-1:0] PDIR,
   input  logic [NUM_PORTS-1:0]        C1,
   input  logic [NUM_PORTS-1:0]        C2I,
   output logic [NUM_PORTS-1:0]        C2O,
   output logic [NUM_PORTS-1:0]        irq
`ifdef PIA_IRQ_COMBINED_EN
   ,
   output logic                        irq_any
`endif
);

   logic [RS_W-1:0]   idx;
   logic [PORT_W-1:0] rdata [NUM_PORTS];
   logic [PORT_W-1:0] rd_mux;
   logic [PORT_W-1:0] do_q, do_d;

   // Upper RS bits pick the port; indices with no port match nothing
   assign idx = bus.RS >> 1;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      pia_port #(
         .PORT_W       (PORT_W),
         .PULSE_CYCLES (PULSE_CYCLES),
         .WSTROBE      (WSTROBE_MASK[g])
      ) u_port (
         .clk_i    (enable),
         .nreset_i (nreset),
         .acc_i    (bus.cs && (idx == RS_W'(g))),
         .rw_i     (bus.rw),
         .rs0_i    (bus.RS[0]),
         .di_i     (bus.DI),
         .pi_i     (PI[g*PORT_W +: PORT_W]),
         .c1_i     (C1[g]),
         .c2i_i    (C2I[g]),
         .po_o     (PO[g*PORT_W +: PORT_W]),
         .pdir_o   (PDIR[g*PORT_W +: PORT_W]),
         .rdata_o  (rdata[g]),
         .c2o_o    (C2O[g]),
         .irq_o    (irq[g])
      );
   end

   // Read mux over the ports; zero for a non-read or unpopulated index
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (idx == RS_W'(i)) rd_mux = rdata[i];
      end
      do_d = (bus.cs && bus.rw) ? rd_mux : '0;
   end

   // DO register, loaded on every cycle so idle cycles return zero
   always_ff @(posedge enable) begin
      if (!nreset) do_q <= '0;
      else         do_q <= do_d;
   end

   assign bus.DO = do_q;

`ifdef PIA_IRQ_COMBINED_EN
   // Every irq bit is a flop with the same reset, so their AND has irq timing
   assign irq_any = &irq;
`endif

endmodule

// File: tb/tb_pia_multiport.sv
// Directed bench for pia_multiport (3 ports so an unpopulated index exists).
// Stimulus pushes expected values into a scoreboard tagged with the cycle in
// which they must hold; a monitor compares them shortly after each falling edge.
module tb_pia_multiport;

   localparam int NP = 3;
   localparam int PW = 8;
   localparam int RW = 3;

   localparam int K_DO   = 0;
   localparam int K_C2O  = 1;
   localparam int K_IRQ  = 2;
   localparam int K_PO   = 3;
   localparam int K_PDIR = 4;
   localparam int K_ANY  = 5;

   typedef struct {
      string       nm;
      int          kind;
      int          due;
      logic [31:0] val;
   } exp_t;

   logic              clk = 1'b0;
   logic              nreset;
   logic [NP*PW-1:0]  PI, PO, PDIR;
   logic [NP-1:0]     C1, C2I, C2O, irq;
`ifdef PIA_IRQ_COMBINED_EN
   logic              irq_any;
`endif

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   pia_multiport_if #(.PORT_W(PW), .RS_W(RW)) bus ();

   pia_multiport #(
      .NUM_PORTS    (NP),
      .PORT_W       (PW),
      .PULSE_CYCLES (3),
      .WSTROBE_MASK (8'b0000_0010)
   ) dut (
      .enable (clk),
      .nreset (nreset),
      .bus    (bus),
      .PI     (PI),
      .PO     (PO),
      .PDIR   (PDIR),
      .C1     (C1),
      .C2I    (C2I),
      .C2O    (C2O),
      .irq    (irq)
`ifdef PIA_IRQ_COMBINED_EN
      ,
      .irq_any (irq_any)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] act_of(int k);
      case (k)
         K_DO:    return 32'(bus.DO);
         K_C2O:   return 32'(C2O);
         K_IRQ:   return 32'(irq);
         K_PO:    return 32'(PO);
         K_PDIR:  return 32'(PDIR);
`ifdef PIA_IRQ_COMBINED_EN
         K_ANY:   return 32'(irq_any);
`endif
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(int kind, string nm, int due, logic [31:0] v);
      exp_t e;
      e.nm   = nm;
      e.kind = kind;
      e.due  = due;
      e.val  = v;
      sb.push_back(e);
   endtask

   // expectation on the outputs as they stand in the current cycle
   task automatic chk(int kind, string nm, logic [31:0] v);
      push(kind, nm, cyc, v);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         bus.cs = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wr(logic [1:0] p, logic r0, logic [7:0] d);
      bus.cs = 1'b1;
      bus.rw = 1'b0;
      bus.RS = {p, r0};
      bus.DI = d;
      @(negedge clk);
      bus.cs = 1'b0;
   endtask

   task automatic rd(logic [1:0] p, logic r0, logic [7:0] e, string nm);
      bus.cs = 1'b1;
      bus.rw = 1'b1;
      bus.RS = {p, r0};
      bus.DI = 8'h00;
      push(K_DO, nm, cyc + 1, 32'(e));
      @(negedge clk);
      bus.cs = 1'b0;
   endtask

   // scoreboard monitor: compares every entry that falls due this cycle
   initial begin
      forever begin
         @(negedge clk);
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
               checks++;
               if (sb[i].due < cyc) begin
                  errors++;
                  $display("FAIL %s: entry for cycle %0d not checked (now %0d)",
                           sb[i].nm, sb[i].due, cyc);
               end else if (act_of(sb[i].kind) !== sb[i].val) begin
                  errors++;
                  $display("FAIL %s: got %h expected %h", sb[i].nm,
                           act_of(sb[i].kind), sb[i].val);
               end
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      nreset = 1'b0;
      bus.cs = 1'b0;
      bus.rw = 1'b1;
      bus.RS = '0;
      bus.DI = '0;
      PI     = {NP{8'hA5}};
      C1     = '0;
      C2I    = '0;
      @(negedge clk);
      idle(2);
      chk(K_DO,   "rst_do",   32'h0);
      chk(K_C2O,  "rst_c2o",  32'h7);
      chk(K_IRQ,  "rst_irq",  32'h7);
      chk(K_PO,   "rst_po",   32'h0);
      chk(K_PDIR, "rst_pdir", 32'h0);
      nreset = 1'b1;
      idle(1);

      // port 0 data path: DDR, CR select, OR, mixed read
      wr(2'd0, 1'b0, 8'hF0);
      wr(2'd0, 1'b1, 8'h04);
      wr(2'd0, 1'b0, 8'h3C);
      chk(K_PDIR, "ddr0_vis", 32'h0000F0);
      chk(K_PO,   "or0_vis",  32'h00003C);
      rd(2'd0, 1'b0, 8'h35, "rd_or0_mix");
      rd(2'd0, 1'b1, 8'h04, "rd_cr0");
      idle(1);
      chk(K_DO, "do_idle_zero", 32'h0);

      // C1 rising edge flag with the n+2 latency, cleared by an OR read
      wr(2'd0, 1'b1, 8'h07);
      C1[0] = 1'b1;
      idle(2);
      chk(K_IRQ, "c1_not_yet", 32'h7);
      idle(1);
      chk(K_IRQ, "c1_irq_set", 32'h6);
      rd(2'd0, 1'b1, 8'h87, "rd_cr0_flag");
      rd(2'd0, 1'b0, 8'h35, "rd_or0_clr");
      chk(K_IRQ, "c1_irq_clr", 32'h7);
      rd(2'd0, 1'b1, 8'h07, "rd_cr0_clr");

      // port 1 pulse mode, write-triggered, with retrigger and CR override
      wr(2'd1, 1'b1, 8'h2C);
      chk(K_C2O, "pulse_idle", 32'h7);
      wr(2'd1, 1'b0, 8'h55);
      chk(K_PO, "or1_vis", 32'h00553C);
      for (int i = 0; i < 3; i++) begin
         chk(K_C2O, $sformatf("pulse_low%0d", i), 32'h5);
         idle(1);
      end
      chk(K_C2O, "pulse_end", 32'h7);
      rd(2'd1, 1'b0, 8'hA5, "rd_or1");
      chk(K_C2O, "read_no_pulse0", 32'h7);
      idle(1);
      chk(K_C2O, "read_no_pulse1", 32'h7);
      wr(2'd1, 1'b0, 8'h11);
      idle(1);
      wr(2'd1, 1'b0, 8'h22);
      for (int i = 0; i < 3; i++) begin
         chk(K_C2O, $sformatf("retrig_low%0d", i), 32'h5);
         idle(1);
      end
      chk(K_C2O, "retrig_end", 32'h7);
      wr(2'd1, 1'b0, 8'h33);
      chk(K_C2O, "mid_low", 32'h5);
      wr(2'd1, 1'b1, 8'h3C);
      chk(K_C2O, "mid_cr_high", 32'h7);
      wr(2'd1, 1'b1, 8'h2C);
      chk(K_C2O, "mid_cr_pulse", 32'h7);
      idle(1);
      chk(K_C2O, "mid_no_resume", 32'h7);

      // port 0 handshake: read-triggered, released by a C1 falling edge
      wr(2'd0, 1'b1, 8'h24);
      rd(2'd0, 1'b0, 8'h35, "hs_trig_rd");
      chk(K_C2O, "hs_low0", 32'h6);
      idle(2);
      chk(K_C2O, "hs_low1", 32'h6);
      C1[0] = 1'b0;
      idle(2);
      chk(K_C2O, "hs_low2", 32'h6);
      idle(1);
      chk(K_C2O, "hs_release", 32'h7);
      chk(K_IRQ, "hs_no_irq", 32'h7);
      rd(2'd0, 1'b1, 8'hA4, "hs_cr0_flag");
      rd(2'd0, 1'b0, 8'h35, "hs_retrig_rd");
      chk(K_C2O, "hs_low3", 32'h6);
      wr(2'd0, 1'b1, 8'h07);
      chk(K_C2O, "c2_input_high", 32'h7);

      // flag set coinciding with a clearing OR read: set wins
      C1[0] = 1'b1;
      idle(2);
      rd(2'd0, 1'b0, 8'h35, "coin_rd");
      chk(K_IRQ, "coin_irq", 32'h6);
      rd(2'd0, 1'b1, 8'h87, "coin_cr0");
      rd(2'd0, 1'b0, 8'h35, "coin_clr_rd");
      chk(K_IRQ, "coin_irq_clr", 32'h7);

      // reset in the middle of a pulse
      wr(2'd1, 1'b0, 8'h77);
      chk(K_C2O, "rp_low0", 32'h5);
      idle(1);
      chk(K_C2O, "rp_low1", 32'h5);
      nreset = 1'b0;
      idle(1);
      chk(K_C2O, "rp_c2o", 32'h7);
      chk(K_PO,  "rp_po",  32'h0);
      chk(K_IRQ, "rp_irq", 32'h7);
      nreset = 1'b1;
      rd(2'd1, 1'b1, 8'h00, "rp_cr1");
      rd(2'd0, 1'b1, 8'h00, "rp_cr0");
      chk(K_IRQ, "rp_no_spur", 32'h7);

      // C2 input flag: suppressed while C2 is an output, set when an input
      wr(2'd1, 1'b1, 8'h3C);
      C2I[1] = 1'b1;
      idle(4);
      rd(2'd1, 1'b1, 8'h3C, "c2out_noflag");
      wr(2'd1, 1'b1, 8'h08);
      C2I[1] = 1'b0;
      idle(2);
      chk(K_IRQ, "c2_not_yet", 32'h7);
      idle(1);
      chk(K_IRQ, "c2_irq_set", 32'h5);
`ifdef PIA_IRQ_COMBINED_EN
      chk(K_ANY, "any_low", 32'h0);
`endif
      rd(2'd1, 1'b1, 8'h48, "c2_cr1_flag");
      wr(2'd1, 1'b1, 8'h0C);
      rd(2'd1, 1'b0, 8'hA5, "c2_clr_rd");
      chk(K_IRQ, "c2_irq_clr", 32'h7);
`ifdef PIA_IRQ_COMBINED_EN
      chk(K_ANY, "any_high", 32'h1);
`endif

      // unpopulated port index and port 2 sanity
      wr(2'd3, 1'b0, 8'hFF);
      wr(2'd3, 1'b1, 8'hFF);
      chk(K_PO,   "oor_po",   32'h0);
      chk(K_PDIR, "oor_pdir", 32'h0);
      rd(2'd3, 1'b0, 8'h00, "oor_rd_data");
      rd(2'd3, 1'b1, 8'h00, "oor_rd_cr");
      wr(2'd2, 1'b0, 8'h5A);
      chk(K_PDIR, "ddr2_vis", 32'h5A0000);
      rd(2'd2, 1'b0, 8'h5A, "rd_ddr2");
      idle(3);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: %0d entries pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
